pal_loader: RTL

- Writer side of the palette-RAM load interface (load_color / load_color_data / load_color_index) consumed by the video block.
- Takes the byte-wide ioctl download stream from the HPS and receives a user .pal file: 64 entries of R,G,B bytes, 192 bytes total.
- Converts each entry to 15-bit {B5,G5,R5}, which is the layout the pixel path expects.
- Writes each entry into the custom palette slot, which the video block selects with palette=14.

---
 rtl/nes_pal_pkg.sv | 29 ++
 rtl/pal_loader_if.sv | 40 ++++
 rtl/pal_loader_rgb888_to_555.sv | 27 ++
 rtl/pal_loader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/nes_pal_pkg.sv
// ---------------------------------------------------------------------------
// nes_pal_pkg
// Shared types and constants for the palette loader.
//   pal_state_t        : loader FSM states (CLEAR exists only in builds that
//                        define PAL_LOADER_CLEAR_EN; the encoding is always
//                        reserved so debug tooling sees one layout)
//   rgb555_t           : one palette entry as the pixel path expects it
//   PAL_BYTES_PER_ENTRY: R, G, B bytes per entry in a .pal file
//   PAL_DEFAULT_INDEX  : ioctl_index used by the HPS for palette downloads
// ---------------------------------------------------------------------------
package nes_pal_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RECV  = 2'd2,
        SKIP  = 2'd3
    } pal_state_t;

    typedef struct packed {
        logic [4:0] b;
        logic [4:0] g;
        logic [4:0] r;
    } rgb555_t;

    localparam int         PAL_BYTES_PER_ENTRY = 3;
    localparam logic [7:0] PAL_DEFAULT_INDEX   = 8'h02;

endpackage

// File: rtl/pal_loader_if.sv
// ---------------------------------------------------------------------------
// pal_loader_if
// Bundles the HPS ioctl download stream and the palette-RAM write port.
//   master : HPS/test side - drives ioctl_*, observes everything else
//   slave  : pal_loader    - consumes ioctl_*, drives ioctl_wait, load_color*,
//            pal_valid and dbg_state
//
// Handshake: ioctl_wr is a one-cycle strobe; the byte on ioctl_dout/ioctl_addr
// is taken on every clk edge where ioctl_wr is high (no ready/ack per byte).
// The only back-pressure is ioctl_wait: while it is high the HPS must not
// raise ioctl_wr. load_color is a one-cycle strobe with no back-pressure;
// load_color_index/load_color_data are valid while it is high and hold
// their last value afterwards.
// dbg_state mirrors the loader FSM state (nes_pal_pkg::pal_state_t encoding).
// ---------------------------------------------------------------------------
interface pal_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        load_color;
    logic [5:0]  load_color_index;
    logic [14:0] load_color_data;
    logic        pal_valid;
    logic [1:0]  dbg_state;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ioctl_wait, load_color, load_color_index, load_color_data,
               pal_valid, dbg_state
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output ioctl_wait, load_color, load_color_index, load_color_data,
               pal_valid, dbg_state
    );
endinterface

// File: rtl/pal_loader_rgb888_to_555.sv
// ---------------------------------------------------------------------------
// pal_rgb888_to_555
// Combinational 8-bit to 5-bit colour channel conversion.
//   c8 : 8-bit channel in
//   c5 : 5-bit channel out
// ROUND = 0 : truncate, c5 = c8[7:3]
// ROUND = 1 : round half-up, c5 = min(31, (c8 + 4) >> 3)
// ---------------------------------------------------------------------------
module pal_rgb888_to_555 #(
    parameter int ROUND = 1
) (
    input  logic [7:0] c8,
    output logic [4:0] c5
);

    always_comb begin
        if (ROUND == 0) begin
            c5 = c8[7:3];
        end else if (c8 >= 8'd252) begin
            // 252..255 would round to 32, which does not fit in 5 bits
            c5 = 5'd31;
        end else begin
            c5 = 5'((c8 + 8'd4) >> 3);
        end
    end

endmodule

// File: rtl/pal_loader.sv
// ---------------------------------------------------------------------------
// pal_loader
// Receives a user .pal file (PAL_ENTRIES x {R,G,B} bytes) over the HPS ioctl
// download stream and writes each entry, converted to {B5,G5,R5}, into the
// custom palette slot of the video block's palette RAM.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : pal_loader_if.slave - ioctl stream in, ioctl_wait,
//             load_color/_index/_data, pal_valid, dbg_state out
// Optional build macro PAL_LOADER_CLEAR_EN: on each palette download start,
// sweep zeros into every entry (ioctl_wait held high) before receiving.
// ---------------------------------------------------------------------------
module pal_loader
    import nes_pal_pkg::*;
#(
    parameter logic [7:0] PAL_IOCTL_INDEX = PAL_DEFAULT_INDEX,
    parameter int         PAL_ENTRIES     = 64,
    parameter int         ROUND           = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    pal_loader_if.slave  bus
);

    localparam int               CNT_W     = $clog2(PAL_ENTRIES + 1);
    localparam logic [CNT_W-1:0] ENT_FULL  = CNT_W'(PAL_ENTRIES);
    localparam logic [1:0]       PH_R      = 2'd0;
    localparam logic [1:0]       PH_G      = 2'd1;
    localparam logic [1:0]       PH_B      = 2'(PAL_BYTES_PER_ENTRY - 1);

    pal_state_t       state_q, state_n;
    logic [CNT_W-1:0] entry_q, entry_n, entry_eff;
    logic [1:0]       phase_q, phase_n, phase_eff;
    logic [4:0]       r5_q, r5_n, g5_q, g5_n;
    logic             lc_q, lc_n;
    logic [5:0]       idx_q, idx_n;
    rgb555_t          data_q, data_n;
    logic             valid_q, valid_n;
    logic             sel, sel_q, sel_rise;
    logic [4:0]       c5;

`ifdef PAL_LOADER_CLEAR_EN
    localparam logic [5:0] CLR_LAST = 6'(PAL_ENTRIES - 1);
    logic [5:0] clr_q, clr_n;
    logic       wait_q, wait_n;
`endif

    assign sel      = bus.ioctl_download && (bus.ioctl_index == PAL_IOCTL_INDEX);
    assign sel_rise = sel && !sel_q;

    // One converter serves all three byte phases: only one byte arrives per cycle.
    pal_rgb888_to_555 #(.ROUND(ROUND)) u_conv (
        .c8 (bus.ioctl_dout),
        .c5 (c5)
    );

    always_comb begin
        state_n   = state_q;
        entry_n   = entry_q;
        phase_n   = phase_q;
        r5_n      = r5_q;
        g5_n      = g5_q;
        lc_n      = 1'b0;
        idx_n     = idx_q;
        data_n    = data_q;
        valid_n   = valid_q;
        entry_eff = entry_q;
        phase_eff = phase_q;
`ifdef PAL_LOADER_CLEAR_EN
        clr_n     = clr_q;
        wait_n    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (sel_rise) begin
                    valid_n = 1'b0;
                    entry_n = '0;
                    phase_n = PH_R;
`ifdef PAL_LOADER_CLEAR_EN
                    clr_n   = '0;
                    state_n = CLEAR;
`else
                    state_n = RECV;
`endif
                end
            end
`ifdef PAL_LOADER_CLEAR_EN
            CLEAR: begin
                lc_n   = 1'b1;
                idx_n  = clr_q;
                data_n = '0;
                if (clr_q == CLR_LAST) begin
                    // A download that ended during the sweep gets no RECV phase.
                    state_n = sel ? RECV : IDLE;
                end else begin
                    clr_n = clr_q + 6'd1;
                end
            end
`endif
            RECV: begin
                if (!sel) begin
                    // Short file: drop the partial entry, keep what was written.
                    phase_n = PH_R;
                    state_n = IDLE;
                end else if (bus.ioctl_wr) begin
                    if (bus.ioctl_addr == 25'd0) begin
                        entry_eff = '0;
                        phase_eff = PH_R;
                        entry_n   = '0;
                    end
                    case (phase_eff)
                        PH_R: begin
                            r5_n    = c5;
                            phase_n = PH_G;
                        end
                        PH_G: begin
                            g5_n    = c5;
                            phase_n = PH_B;
                        end
                        default: begin
                            lc_n    = 1'b1;
                            idx_n   = 6'(entry_eff);
                            data_n  = '{b: c5, g: g5_q, r: r5_q};
                            phase_n = PH_R;
                            entry_n = entry_eff + 1'b1;
                            if (entry_n == ENT_FULL) begin
                                valid_n = 1'b1;
                                state_n = SKIP;
                            end
                        end
                    endcase
                end
            end
            SKIP: begin
                if (!sel) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
`ifdef PAL_LOADER_CLEAR_EN
        // Registered so that it also covers the cycle in which the last
        // clear write is presented to the RAM.
        wait_n = (state_n == CLEAR) || (state_q == CLEAR);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            entry_q <= '0;
            phase_q <= PH_R;
            r5_q    <= '0;
            g5_q    <= '0;
            lc_q    <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            // Reset to 1 so a download already in progress when reset is
            // released is not mistaken for a new one; sel must drop first.
            sel_q   <= 1'b1;
`ifdef PAL_LOADER_CLEAR_EN
            clr_q   <= '0;
            wait_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            entry_q <= entry_n;
            phase_q <= phase_n;
            r5_q    <= r5_n;
            g5_q    <= g5_n;
            lc_q    <= lc_n;
            idx_q   <= idx_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            sel_q   <= sel;
`ifdef PAL_LOADER_CLEAR_EN
            clr_q   <= clr_n;
            wait_q  <= wait_n;
`endif
        end
    end

    assign bus.load_color       = lc_q;
    assign bus.load_color_index = idx_q;
    assign bus.load_color_data  = data_q;
    assign bus.pal_valid        = valid_q;
    assign bus.dbg_state        = state_q;
`ifdef PAL_LOADER_CLEAR_EN
    assign bus.ioctl_wait       = wait_q;
`else
    assign bus.ioctl_wait       = 1'b0;
`endif

endmodule
